// File: rtl/elev_call_sched.sv
// SCAN call scheduler for a 4-floor elevator: latches calls, issues a one-hot target
// floor, retires calls on arrival and times the door dwell before the next target.
module elev_call_sched #(
  parameter int N_FLOORS  = 4,
  parameter int DWELL_CYC = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] i_call,
  input  logic [N_FLOORS-1:0] rec_floor,
  output logic [N_FLOORS-1:0] req_floor,
  output logic [N_FLOORS-1:0] o_pending,
  output logic                o_dir_up,
  output logic                o_busy
);

  localparam int IW = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;
  localparam int CW = $clog2(DWELL_CYC + 1);
  localparam logic [N_FLOORS-1:0] ONE      = N_FLOORS'(1);
  localparam logic [CW-1:0]       CNT_LOAD = CW'(DWELL_CYC - 1);

  // IDLE: waiting for work | SERVE: travelling to req_floor | DWELL: door open at arrival floor
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic [N_FLOORS-1:0] req_q, req_d;
  logic                dir_q, dir_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic                cur_valid;
  logic [IW-1:0]       cur_idx, req_idx;
  logic                above_any, below_any, btw_up_any, btw_dn_any;
  logic [IW-1:0]       above_idx, below_idx, btw_up_idx, btw_dn_idx;
  logic [IW-1:0]       tgt_idx;
  logic                tgt_dir;
  logic [N_FLOORS-1:0] clr;

  assign cur_valid = $onehot(rec_floor);

  always_comb begin
    cur_idx = '0;
    req_idx = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (rec_floor[i]) cur_idx = IW'(i);
      if (req_q[i])     req_idx = IW'(i);
    end
  end

  // Descending scans leave the lowest hit, ascending scans the highest hit: the nearest one.
  always_comb begin
    above_any  = 1'b0;
    above_idx  = '0;
    btw_up_any = 1'b0;
    btw_up_idx = '0;
    for (int i = N_FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && (IW'(i) > cur_idx)) begin
        above_any = 1'b1;
        above_idx = IW'(i);
      end
      if (pending_q[i] && (IW'(i) > cur_idx) && (IW'(i) < req_idx)) begin
        btw_up_any = 1'b1;
        btw_up_idx = IW'(i);
      end
    end
    below_any  = 1'b0;
    below_idx  = '0;
    btw_dn_any = 1'b0;
    btw_dn_idx = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pending_q[i] && (IW'(i) < cur_idx)) begin
        below_any = 1'b1;
        below_idx = IW'(i);
      end
      if (pending_q[i] && (IW'(i) < cur_idx) && (IW'(i) > req_idx)) begin
        btw_dn_any = 1'b1;
        btw_dn_idx = IW'(i);
      end
    end
  end

  always_comb begin
    tgt_idx = above_idx;
    tgt_dir = 1'b1;
    if (dir_q) begin
      if (!above_any) begin
        tgt_idx = below_idx;
        tgt_dir = 1'b0;
      end
    end else if (below_any) begin
      tgt_idx = below_idx;
      tgt_dir = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    clr     = '0;
    case (state_q)
      S_IDLE: begin
        if (cur_valid && (pending_q != '0)) begin
          if ((pending_q & rec_floor) != '0) begin
            clr     = rec_floor;
            cnt_d   = CNT_LOAD;
            state_d = S_DWELL;
          end else begin
            req_d   = ONE << tgt_idx;
            dir_d   = tgt_dir;
            state_d = S_SERVE;
          end
        end
      end
      S_SERVE: begin
        if (rec_floor == req_q) begin
          clr     = rec_floor;
          cnt_d   = CNT_LOAD;
          state_d = S_DWELL;
        end else if (cur_valid) begin
          if (dir_q && btw_up_any)       req_d = ONE << btw_up_idx;
          else if (!dir_q && btw_dn_any) req_d = ONE << btw_dn_idx;
        end
      end
      S_DWELL: begin
        // Calls at the open door are absorbed rather than latched.
        if (cur_valid) clr = rec_floor;
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pending_d = (pending_q | i_call) & ~clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      req_q     <= ONE;
      dir_q     <= 1'b1;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      req_q     <= req_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
    end
  end

  assign req_floor = req_q;
  assign o_pending = pending_q;
  assign o_dir_up  = dir_q;
  assign o_busy    = (state_q == S_SERVE) || (state_q == S_DWELL);

endmodule
